// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, FSM states,
// byte-lane strobe constants and the legality decode used at accept time.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT_R = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_e;

  // Exactly one of read/write, a listed funct3 for that direction, natural alignment.
  function automatic logic op_legal(input logic rd, input logic wr,
                                    input logic [2:0] f3, input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    if (rd != wr) begin
      case (f3)
        F3_B:    ok = 1'b1;
        F3_H:    ok = !lane[0];
        F3_W:    ok = (lane == 2'b00);
        F3_BU:   ok = rd;
        F3_HU:   ok = rd && !lane[0];
        default: ok = 1'b0;
      endcase
    end
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Memory-side bus of the load/store unit; master is the LSU, slave is memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data replication and load lane extract
// with sign or zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_wstrb,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata_ext
);
  logic [31:0] w_shifted;

  always_comb begin
    w_shifted   = i_rdata >> {i_lane, 3'b000};
    o_wstrb     = STRB_W;
    o_wdata     = i_wdata;
    o_rdata_ext = i_rdata;
    case (i_funct3[1:0])
      2'b00: begin
        o_wstrb     = STRB_B << i_lane;
        o_wdata     = {4{i_wdata[7:0]}};
        o_rdata_ext = i_funct3[2] ? {24'b0, w_shifted[7:0]}
                                  : {{24{w_shifted[7]}}, w_shifted[7:0]};
      end
      2'b01: begin
        o_wstrb     = STRB_H << i_lane;
        o_wdata     = {2{i_wdata[15:0]}};
        o_rdata_ext = i_funct3[2] ? {16'b0, w_shifted[15:0]}
                                  : {{16{w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        o_wstrb     = STRB_W;
        o_wdata     = i_wdata;
        o_rdata_ext = i_rdata;
      end
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the execute stage and a
// word-wide memory with request/grant and read-valid handshakes.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [ADDR_W-1:0]  addr,
  input  logic [DATA_W-1:0]  wdata,
  load_store_unit_if.master  mem,
  output logic               done,
  output logic               err,
  output logic [DATA_W-1:0]  load_data,
  output lsu_state_e         dbg_state
);
  // Handshakes: an op transfers on the rising edge where req_valid && req_ready;
  // the memory request transfers where mem_req && mem_gnt; read data is taken
  // only on mem_rvalid while waiting for it, never in the grant cycle.
  lsu_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_f3;
  logic              r_load;
  logic              r_err;
  logic [DATA_W-1:0] r_load_data;

  logic              w_legal;
  logic              w_req;
  logic [3:0]        w_wstrb;
  logic [31:0]       w_wdata_sh;
  logic [31:0]       w_load_ext;

  assign w_legal = op_legal(mem_read, mem_write, funct3, addr[1:0]);
  assign w_req   = (r_state == ST_REQ);

  lsu_align u_align (
    .i_funct3    (r_f3),
    .i_lane      (r_addr[1:0]),
    .i_wdata     (r_wdata),
    .i_rdata     (mem.mem_rdata),
    .o_wstrb     (w_wstrb),
    .o_wdata     (w_wdata_sh),
    .o_rdata_ext (w_load_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_f3        <= '0;
      r_load      <= 1'b0;
      r_err       <= 1'b0;
      r_load_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_addr  <= addr;
            r_wdata <= wdata;
            r_f3    <= funct3;
            r_load  <= mem_read;
            r_err   <= !w_legal;
            r_state <= w_legal ? ST_REQ : ST_RESP;
          end
        end
        ST_REQ: begin
          if (mem.mem_gnt) r_state <= r_load ? ST_WAIT_R : ST_RESP;
        end
        ST_WAIT_R: begin
          if (mem.mem_rvalid) begin
            r_load_data <= w_load_ext;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_err   <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Bus outputs are driven only while requesting so an idle bus reads as zero.
  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_req && !r_load;
  assign mem.mem_addr  = w_req ? {r_addr[ADDR_W-1:2], 2'b00} : '0;
  assign mem.mem_wdata = (w_req && !r_load) ? w_wdata_sh : '0;
  assign mem.mem_wstrb = (w_req && !r_load) ? w_wstrb : 4'b0000;

  assign req_ready = (r_state == ST_IDLE);
  assign done      = (r_state == ST_RESP);
  assign err       = (r_state == ST_RESP) && r_err;
  assign load_data = r_load_data;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit with a size/lane
// arithmetic reference model and immediate-assertion checks.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  lsu_state_e  dbg_state;

  int          checks;
  int          errors;
  logic [31:0] exp_ld;

  load_store_unit_if #(.ADDR_W(32)) mem_if ();

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .funct3    (funct3),
    .addr      (addr),
    .wdata     (wdata),
    .mem       (mem_if),
    .done      (done),
    .err       (err),
    .load_data (load_data),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: access size in bytes from funct3, lane from address, then plain arithmetic.
  function automatic void model(input logic rd, input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] w,
                                input logic [31:0] rdat, output logic legal,
                                output logic [3:0] strb, output logic [31:0] wd,
                                output logic [31:0] ld);
    int size;
    int lane;
    logic [31:0] mask;
    logic [31:0] v;
    lane = int'(a % 4);
    case (f3)
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0 || rd == wr) legal = 1'b0;
    else if (wr && f3 > 3'd2) legal = 1'b0;
    else legal = (lane % size) == 0;
    if (size == 0) size = 4;
    strb = 4'(((1 << size) - 1) << lane);
    wd   = (size == 1) ? w[7:0] * 32'h01010101 :
           (size == 2) ? w[15:0] * 32'h00010001 : w;
    mask = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
    v    = (rdat >> (8 * lane)) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
    ld = v;
  endfunction

  task automatic do_op(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] w, input logic [31:0] rdat,
                       input int gd, input int rvd, input logic stale);
    logic        legal;
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [31:0] ld;
    model(rd, wr, f3, a, w, rdat, legal, strb, wd, ld);
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; mem_read = rd; mem_write = wr; funct3 = f3; addr = a; wdata = w;
    @(posedge clk); #1;
    req_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    if (!legal) begin
      @(negedge clk);
      chk("err_done", done, 1'b1);
      chk("err_flag", err, 1'b1);
      chk("err_no_req", mem_if.mem_req, 1'b0);
      chk("err_ld_keep", load_data, exp_ld);
    end else begin
      for (int i = 0; i <= gd; i++) begin
        @(negedge clk);
        if (i == gd) begin
          mem_if.mem_gnt = 1'b1;
          mem_if.mem_rvalid = stale;
          mem_if.mem_rdata = ~rdat;
        end
        chk("mem_req", mem_if.mem_req, 1'b1);
        chk("mem_we", mem_if.mem_we, wr);
        chk("mem_addr", mem_if.mem_addr, {a[31:2], 2'b00});
        chk("mem_wstrb", mem_if.mem_wstrb, wr ? strb : 4'b0000);
        chk("mem_wdata", mem_if.mem_wdata, wr ? wd : 32'h0);
        chk("no_early_done", done, 1'b0);
        @(posedge clk); #1;
        mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0;
      end
      if (rd) begin
        for (int i = 0; i <= rvd; i++) begin
          @(negedge clk);
          if (i == rvd) begin
            mem_if.mem_rvalid = 1'b1;
            mem_if.mem_rdata = rdat;
          end
          chk("wait_no_req", mem_if.mem_req, 1'b0);
          chk("wait_no_done", done, 1'b0);
          @(posedge clk); #1;
          mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = $urandom;
        end
        exp_ld = ld;
      end
      @(negedge clk);
      chk("done", done, 1'b1);
      chk("err_clear", err, 1'b0);
      chk("load_data", load_data, exp_ld);
    end
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
  endtask

  initial begin
    checks = 0; errors = 0; exp_ld = 32'h0;
    rst_n = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_ready", req_ready, 1'b1);
    chk("rst_mem_req", mem_if.mem_req, 1'b0);
    chk("rst_mem_we", mem_if.mem_we, 1'b0);
    chk("rst_mem_addr", mem_if.mem_addr, 32'h0);
    chk("rst_mem_wdata", mem_if.mem_wdata, 32'h0);
    chk("rst_mem_wstrb", mem_if.mem_wstrb, 4'b0000);
    chk("rst_done", done, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_load_data", load_data, 32'h0);
    rst_n = 1'b1;

    do_op(1'b0, 1'b1, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 1'b1, F3_B,  32'h0000_0103, 32'h0000_00A5, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 1'b1, F3_H,  32'h0000_0102, 32'h1234_5678, 32'h0, 1, 0, 1'b0);
    do_op(1'b1, 1'b0, F3_B,  32'h0000_0102, 32'h0, 32'h12F0_3456, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, F3_BU, 32'h0000_0102, 32'h0, 32'h12F0_3456, 0, 0, 1'b1);
    do_op(1'b1, 1'b0, F3_W,  32'h0000_0202, 32'h0, 32'h0, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, F3_H,  32'h0000_0300, 32'h0, 32'hABCD_8765, 5, 2, 1'b0);
    do_op(1'b1, 1'b1, F3_W,  32'h0000_0400, 32'h0, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 1'b0, F3_W,  32'h0000_0400, 32'h0, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 1'b1, F3_BU, 32'h0000_0400, 32'h0, 32'h0, 0, 0, 1'b0);
    do_op(1'b1, 1'b0, F3_HU, 32'h0000_0501, 32'h0, 32'h0, 0, 0, 1'b0);
    do_op(1'b0, 1'b1, F3_H,  32'h0000_0503, 32'h0, 32'h0, 0, 0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      logic rd;
      logic wr;
      rd = ($urandom_range(0, 9) < 5);
      wr = ($urandom_range(0, 9) == 0) ? rd : !rd;
      do_op(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    // Abort a load while it waits for read data.
    @(negedge clk);
    req_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; funct3 = F3_W; addr = 32'h0000_0600;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    mem_if.mem_gnt = 1'b1;
    chk("abort_req", mem_if.mem_req, 1'b1);
    @(posedge clk); #1;
    mem_if.mem_gnt = 1'b0;
    @(negedge clk);
    chk("abort_wait_state", dbg_state, ST_WAIT_R);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_req", mem_if.mem_req, 1'b0);
    chk("abort_no_done", done, 1'b0);
    @(posedge clk); #1;
    mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    chk("abort_no_done_rst", done, 1'b0);
    rst_n = 1'b1; mem_if.mem_rvalid = 1'b0;
    exp_ld = 32'h0;
    @(negedge clk);
    chk("abort_ready", req_ready, 1'b1);
    chk("abort_done_after", done, 1'b0);
    chk("abort_load_data", load_data, exp_ld);
    do_op(1'b1, 1'b0, F3_H, 32'h0000_0702, 32'h0, 32'h7FFF_0001, 0, 1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
